step_dir: RTL and testbench
===========================

# step_dir

Per-channel step/direction pulse generator for the stepper unit. It holds a FIFO of queued moves and replays each one as a timed sequence of step pulses against the free-running system clock. The timing follows Klipper `queue_step` semantics: step interval, step count and per-step interval add. The stepper command decoder instantiates one copy per motor channel; the endstop logic drives its `reset`.

## Interface
Parameters:
- `MOVE_TYPE_KLIPPER`, default 3'b000: move-type code that is executed.
- `MOVE_TYPE_BITS`, default 3: width of the move-type field.
- `STEP_INTERVAL_BITS`, default 32: interval field width.
- `STEP_COUNT_BITS`, default 32: count field width.
- `STEP_ADD_BITS`, default 32: add field width; the add value is signed two's complement.
- `MOVE_COUNT`, default 512: FIFO depth in entries.
- `STEP_PULSE_CYCLES`, default 32: high time of a single-edge step pulse, in cycles.

Ports (W = 1 + INTERVAL + COUNT + ADD + TYPE bits = 100 by default):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `queue_wr_data` in W: move entry, packed MSB→LSB as {dir, interval, count, add, type}.
- `queue_wr_en` in 1: push `queue_wr_data` into the FIFO.
- `queue_empty` out 1: FIFO holds no entries.
- `running` out 1: a move is loaded and still has steps outstanding.
- `reset` in 1: synchronous flush/abort.
- `dedge` in 1: 1 selects double-edge stepping.
- `do_reset_clock` in 1: load `reset_clock` into the step time base.
- `reset_clock` in 32: new step time base.
- `clock` in 32: system time; increments by 1 per cycle and wraps.
- `step` out 1: step output.
- `dir` out 1: direction output.
- `position` out 32: signed step position.

## Operation
- Reset values under `rst_n`=0:
  - `step`=0, `dir`=0, `position`=0, `running`=0.
  - FIFO empty, so `queue_empty`=1.
  - Time base = 0.
- FIFO:
  - A push while full is dropped.
  - A push and a pop in the same cycle are both honoured.
- Load: when not running and the FIFO is not empty, the entry is popped. On the next cycle:
  - `dir` ← entry.dir.
  - cur_int ← interval.
  - next_time ← base + interval.
  - remaining ← count.
  - `running` ← 1.
- Discarded entries: an entry with count=0 or with type ≠ `MOVE_TYPE_KLIPPER` is popped and discarded; no steps are issued and `running` stays 0.
- Fire condition: while running, a step fires when $signed(`clock` − next_time) ≥ 0. The comparison is wrap-safe.
- On fire:
  - base ← next_time.
  - cur_int ← cur_int + add.
  - next_time ← next_time + cur_int + add.
  - remaining ← remaining − 1.
  - `position` ← ±1: +1 if `dir`=1, −1 if `dir`=0, wrapping modulo 2^32.
  - When remaining reaches 0, `running` drops in the following cycle.
- Chaining: base persists after a move ends, so the next move is timed from the last step of the previous move.
- `do_reset_clock`: base ← `reset_clock`. It takes effect on the next load. It is ignored while running.
- `reset`:
  - FIFO is flushed and the current move is aborted (`running`=0).
  - A single-edge pulse in progress still completes its high time.
  - `position`, `dir` and base are retained.
  - If `reset` and `queue_wr_en` are asserted together, `reset` wins and the entry is dropped.
- Step output:
  - `dedge`=0: each fire drives `step` high for `STEP_PULSE_CYCLES` cycles.
  - `dedge`=1: each fire toggles `step`.

## Timing
- `step` and `position` are registered: they change one cycle after the fire cycle. If base = T−1, the step edge appears when `clock` = T + interval.
- Load latency:
  - FIFO read is one cycle.
  - The next move loads no earlier than the cycle after `running` drops.
  - `dir` is updated at load, which is at least one cycle before that move's first step edge.
- `queue_empty` updates one cycle after a push or pop.
- `do_reset_clock` is a single-cycle pulse; base is updated on the next cycle.

## Configuration
- `STEPDIR_DEDGE_EN` defined: the `dedge` input selects toggle stepping, as described under Operation.
- `STEPDIR_DEDGE_EN` undefined: `dedge` is ignored and stepping is always single-pulse of `STEP_PULSE_CYCLES`.

## Test plan
- Single move: reset_clock=999, entry {dir=1, int=100, cnt=3, add=0} → step rises at clock 1100, 1200, 1300; position=3; running=0 after the last step.
- Add: base=0, {dir=0, int=50, cnt=3, add=10} → steps at clock 51, 111, 181; position=−3.
- Chaining and dir change: two back-to-back entries, {1, 100, 2, 0} then {0, 100, 2, 0} → 4 evenly spaced steps; dir falls before the 3rd step; final position=0.
- dedge=1: 4 steps → step toggles 4 times and ends at 0; with `STEPDIR_DEDGE_EN` undefined → 4 pulses of 32 cycles each.
- Abort: `reset` asserted after 2 of 10 steps with 3 entries queued → queue_empty=1, running=0, position stays 2, no further steps.
- Wrap: base=32'hFFFFFFF0, int=0x20 → step fires at clock 0x10; a full FIFO (512 entries) drops the 513th push.

Source files
------------

// File: rtl/step_dir.sv
// Step/direction pulse generator: replays queued Klipper-style moves (interval, count, add) as timed step pulses.
// Optional STEPDIR_DEDGE_EN enables toggle (double-edge) stepping selected by the dedge input.
module step_dir #(
   parameter int MOVE_TYPE_BITS = 3,
   parameter logic [MOVE_TYPE_BITS-1:0] MOVE_TYPE_KLIPPER = '0,
   parameter int STEP_INTERVAL_BITS = 32,
   parameter int STEP_COUNT_BITS = 32,
   parameter int STEP_ADD_BITS = 32,
   parameter int MOVE_COUNT = 512,
   parameter int STEP_PULSE_CYCLES = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic [STEP_INTERVAL_BITS+STEP_COUNT_BITS+STEP_ADD_BITS+MOVE_TYPE_BITS:0] queue_wr_data,
   input  logic queue_wr_en,
   output logic queue_empty,
   output logic running,
   input  logic reset,
   input  logic dedge,
   input  logic do_reset_clock,
   input  logic [31:0] reset_clock,
   input  logic [31:0] clock,
   output logic step,
   output logic dir,
   output logic [31:0] position
);
   localparam int W       = 1 + STEP_INTERVAL_BITS + STEP_COUNT_BITS + STEP_ADD_BITS + MOVE_TYPE_BITS;
   localparam int ADD_LSB = MOVE_TYPE_BITS;
   localparam int CNT_LSB = ADD_LSB + STEP_ADD_BITS;
   localparam int INT_LSB = CNT_LSB + STEP_COUNT_BITS;
   localparam int DIR_BIT = INT_LSB + STEP_INTERVAL_BITS;
   localparam int AW      = (MOVE_COUNT > 1) ? $clog2(MOVE_COUNT) : 1;
   localparam int PW      = $clog2(STEP_PULSE_CYCLES + 1);

   logic [W-1:0]                  r_mem [MOVE_COUNT];
   logic [AW-1:0]                 r_wrPtr, r_rdPtr;
   logic [AW:0]                   r_count;
   logic                          r_running, r_dir, r_step;
   logic [31:0]                   r_base, r_nextTime, r_curInt, r_add, r_position;
   logic [STEP_COUNT_BITS-1:0]    r_remaining;
   logic [PW-1:0]                 r_pulseCnt;

   logic                          w_full, w_push, w_pop, w_loadOk, w_fire, w_toggle;
   logic [W-1:0]                  w_entry;
   logic [STEP_COUNT_BITS-1:0]    w_eCnt;
   logic [MOVE_TYPE_BITS-1:0]     w_eType;
   logic [31:0]                   w_eInt, w_eAdd, w_sinceDue;

`ifdef STEPDIR_DEDGE_EN
   assign w_toggle = dedge;
`else
   logic w_unusedDedge;
   assign w_unusedDedge = dedge;
   assign w_toggle = 1'b0;
`endif

   assign w_full   = (r_count == (AW+1)'(MOVE_COUNT));
   assign w_push   = queue_wr_en && !reset && !w_full;
   assign w_pop    = !r_running && (r_count != '0) && !reset;

   assign w_entry  = r_mem[r_rdPtr];
   assign w_eCnt   = w_entry[CNT_LSB +: STEP_COUNT_BITS];
   assign w_eType  = w_entry[MOVE_TYPE_BITS-1:0];
   assign w_eInt   = 32'(w_entry[INT_LSB +: STEP_INTERVAL_BITS]);
   assign w_eAdd   = 32'($signed(w_entry[ADD_LSB +: STEP_ADD_BITS]));
   assign w_loadOk = (w_eCnt != '0) && (w_eType == MOVE_TYPE_KLIPPER);

   // Signed difference keeps the due-time test correct across 32-bit clock wrap.
   assign w_sinceDue = clock - r_nextTime;
   assign w_fire     = r_running && !reset && !w_sinceDue[31];

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wrPtr] <= queue_wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wrPtr <= (r_wrPtr == AW'(MOVE_COUNT-1)) ? '0 : r_wrPtr + 1'b1;
         if (w_pop)
            r_rdPtr <= (r_rdPtr == AW'(MOVE_COUNT-1)) ? '0 : r_rdPtr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Base persists across moves so consecutive moves chain from the last step time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_running   <= 1'b0;
         r_dir       <= 1'b0;
         r_base      <= '0;
         r_nextTime  <= '0;
         r_curInt    <= '0;
         r_add       <= '0;
         r_remaining <= '0;
      end else begin
         if (reset) begin
            r_running   <= 1'b0;
            r_remaining <= '0;
         end else if (w_pop) begin
            if (w_loadOk) begin
               r_dir       <= w_entry[DIR_BIT];
               r_curInt    <= w_eInt;
               r_add       <= w_eAdd;
               r_nextTime  <= r_base + w_eInt;
               r_remaining <= w_eCnt;
               r_running   <= 1'b1;
            end
         end else if (w_fire) begin
            r_base      <= r_nextTime;
            r_curInt    <= r_curInt + r_add;
            r_nextTime  <= r_nextTime + r_curInt + r_add;
            r_remaining <= r_remaining - 1'b1;
            r_running   <= (r_remaining != STEP_COUNT_BITS'(1));
         end
         if (do_reset_clock && !r_running)
            r_base <= reset_clock;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step     <= 1'b0;
         r_pulseCnt <= '0;
         r_position <= '0;
      end else begin
         if (w_fire) begin
            r_position <= r_dir ? r_position + 32'd1 : r_position - 32'd1;
            if (w_toggle) begin
               r_step     <= ~r_step;
               r_pulseCnt <= '0;
            end else begin
               r_step     <= 1'b1;
               r_pulseCnt <= PW'(STEP_PULSE_CYCLES - 1);
            end
         end else if (r_pulseCnt != '0) begin
            r_pulseCnt <= r_pulseCnt - 1'b1;
         end else if (!w_toggle) begin
            r_step <= 1'b0;
         end
      end
   end

   assign queue_empty = (r_count == '0);
   assign running     = r_running;
   assign step        = r_step;
   assign dir         = r_dir;
   assign position    = r_position;
endmodule

// File: tb/tb_step_dir.sv
// Scoreboard bench for step_dir: expected step edges (clock, position, dir) are queued as moves are driven.
// Works with or without STEPDIR_DEDGE_EN defined.
module tb_step_dir;
   logic        clk = 1'b0;
   logic        rstN;
   logic [99:0] queueWrData;
   logic        queueWrEn;
   logic        queueEmpty;
   logic        runningOut;
   logic        syncReset;
   logic        dedgeIn;
   logic        doResetClock;
   logic [31:0] resetClock;
   logic [31:0] sysClock = '0;
   logic        stepOut;
   logic        dirOut;
   logic [31:0] positionOut;

   logic        setClock = 1'b0;
   logic [31:0] setClockVal = '0;
   logic        toggleMode = 1'b0;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct {
      logic [31:0] clkVal;
      logic [31:0] pos;
      logic        dirVal;
   } stepRec_t;

   stepRec_t    expQ[$];
   logic [31:0] modelBase = '0;
   logic [31:0] modelPos = '0;

   step_dir dut (
      .clk            (clk),
      .rst_n          (rstN),
      .queue_wr_data  (queueWrData),
      .queue_wr_en    (queueWrEn),
      .queue_empty    (queueEmpty),
      .running        (runningOut),
      .reset          (syncReset),
      .dedge          (dedgeIn),
      .do_reset_clock (doResetClock),
      .reset_clock    (resetClock),
      .clock          (sysClock),
      .step           (stepOut),
      .dir            (dirOut),
      .position       (positionOut)
   );

   always #5 clk = ~clk;

   // Free-running system time, with an optional jump so tests can start from chosen time bases.
   always @(posedge clk) begin
      if (setClock)
         sysClock <= setClockVal;
      else
         sysClock <= sysClock + 32'd1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [99:0] makeEntry(input logic d, input logic [31:0] iv, input logic [31:0] cnt,
                                             input logic [31:0] add, input logic [2:0] typ);
      return {d, iv, cnt, add, typ};
   endfunction

   task automatic applyStimulus(input logic [99:0] entry);
      queueWrData = entry;
      queueWrEn   = 1'b1;
      @(negedge clk);
      queueWrEn   = 1'b0;
   endtask

   // Reference timing: first step due at base+interval, each later gap grows by add; edge seen one cycle later.
   task automatic expectSteps(input logic d, input logic [31:0] iv, input int cnt, input logic [31:0] add);
      logic [31:0] nextT, cur;
      stepRec_t    rec;
      nextT = modelBase + iv;
      cur   = iv;
      for (int i = 0; i < cnt; i++) begin
         modelPos   = d ? modelPos + 32'd1 : modelPos - 32'd1;
         rec.clkVal = nextT + 32'd1;
         rec.pos    = modelPos;
         rec.dirVal = d;
         expQ.push_back(rec);
         modelBase  = nextT;
         cur        = cur + add;
         nextT      = nextT + cur;
      end
   endtask

   task automatic rebase(input logic [31:0] val);
      setClock     = 1'b1;
      setClockVal  = val;
      doResetClock = 1'b1;
      resetClock   = val;
      @(negedge clk);
      setClock     = 1'b0;
      doResetClock = 1'b0;
      modelBase    = val;
   endtask

   task automatic waitDrain(input int budget, input string tag);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 64'(expQ.size()), 64'd0);
   endtask

   // Step monitor: each observed step edge is matched against the head of the expected queue.
   logic prevStep = 1'b0;
   int   highCnt = 0;
   always @(negedge clk) begin
      stepRec_t rec;
      logic     stepEdge;
      if (rstN) begin
         stepEdge = toggleMode ? (stepOut != prevStep) : (stepOut && !prevStep);
         if (stepEdge) begin
            if (expQ.size() == 0) begin
               checkOutput("pendingSteps", 64'(expQ.size()), 64'd1);
            end else begin
               rec = expQ.pop_front();
               checkOutput("stepClock", 64'(sysClock), 64'(rec.clkVal));
               checkOutput("stepPosition", 64'(positionOut), 64'(rec.pos));
               checkOutput("stepDir", 64'(dirOut), 64'(rec.dirVal));
            end
         end
         if (!toggleMode) begin
            if (stepOut && !prevStep)
               highCnt = 1;
            else if (stepOut)
               highCnt++;
            else if (prevStep)
               checkOutput("pulseWidth", 64'(highCnt), 64'd32);
         end
         prevStep = stepOut;
      end
   end

   initial begin
      rstN         = 1'b0;
      queueWrData  = '0;
      queueWrEn    = 1'b0;
      syncReset    = 1'b0;
      dedgeIn      = 1'b0;
      doResetClock = 1'b0;
      resetClock   = '0;
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);

      checkOutput("resetStep", 64'(stepOut), 64'd0);
      checkOutput("resetDir", 64'(dirOut), 64'd0);
      checkOutput("resetPosition", 64'(positionOut), 64'd0);
      checkOutput("resetRunning", 64'(runningOut), 64'd0);
      checkOutput("resetEmpty", 64'(queueEmpty), 64'd1);

      // Single move from base 999: edges at 1100, 1200, 1300.
      rebase(32'd999);
      applyStimulus(makeEntry(1'b1, 32'd100, 32'd3, 32'd0, 3'b000));
      expectSteps(1'b1, 32'd100, 3, 32'd0);
      waitDrain(1000, "singleDrain");
      repeat (3) @(negedge clk);
      checkOutput("singleRunning", 64'(runningOut), 64'd0);
      checkOutput("singlePosition", 64'(positionOut), 64'd3);
      repeat (40) @(negedge clk);

      // Signed add from base 0: edges at 51, 111, 181.
      rebase(32'd0);
      applyStimulus(makeEntry(1'b0, 32'd50, 32'd3, 32'd10, 3'b000));
      expectSteps(1'b0, 32'd50, 3, 32'd10);
      waitDrain(1000, "addDrain");
      repeat (40) @(negedge clk);
      checkOutput("addPosition", 64'(positionOut), 64'(modelPos));

      // Discarded entries: zero count and foreign type produce no steps.
      rebase(32'd2000);
      applyStimulus(makeEntry(1'b1, 32'd20, 32'd0, 32'd0, 3'b000));
      applyStimulus(makeEntry(1'b1, 32'd20, 32'd5, 32'd0, 3'b101));
      repeat (3) @(negedge clk);
      checkOutput("discardRunning", 64'(runningOut), 64'd0);
      checkOutput("discardEmpty", 64'(queueEmpty), 64'd1);
      repeat (100) @(negedge clk);

      // Chaining with a direction change between moves.
      rebase(32'd5000);
      applyStimulus(makeEntry(1'b1, 32'd100, 32'd2, 32'd0, 3'b000));
      applyStimulus(makeEntry(1'b0, 32'd100, 32'd2, 32'd0, 3'b000));
      expectSteps(1'b1, 32'd100, 2, 32'd0);
      expectSteps(1'b0, 32'd100, 2, 32'd0);
      waitDrain(1000, "chainDrain");
      repeat (40) @(negedge clk);
      checkOutput("chainPosition", 64'(positionOut), 64'(modelPos));

      // Double-edge request: toggles when enabled, plain pulses otherwise.
      dedgeIn = 1'b1;
`ifdef STEPDIR_DEDGE_EN
      toggleMode = 1'b1;
`endif
      rebase(32'd8000);
      applyStimulus(makeEntry(1'b1, 32'd40, 32'd4, 32'd0, 3'b000));
      expectSteps(1'b1, 32'd40, 4, 32'd0);
      waitDrain(1000, "dedgeDrain");
      repeat (40) @(negedge clk);
      checkOutput("dedgeFinalStep", 64'(stepOut), 64'd0);
      dedgeIn    = 1'b0;
      toggleMode = 1'b0;

      // Abort after two of ten steps with three more entries queued.
      rebase(32'd10000);
      applyStimulus(makeEntry(1'b1, 32'd100, 32'd10, 32'd0, 3'b000));
      for (int i = 0; i < 3; i++)
         applyStimulus(makeEntry(1'b1, 32'd100, 32'd5, 32'd0, 3'b000));
      expectSteps(1'b1, 32'd100, 2, 32'd0);
      waitDrain(1000, "abortDrain");
      syncReset   = 1'b1;
      queueWrData = makeEntry(1'b0, 32'd30, 32'd1, 32'd0, 3'b000);
      queueWrEn   = 1'b1;
      @(negedge clk);
      syncReset   = 1'b0;
      queueWrEn   = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("abortEmpty", 64'(queueEmpty), 64'd1);
      checkOutput("abortRunning", 64'(runningOut), 64'd0);
      checkOutput("abortPulseHeld", 64'(stepOut), 64'd1);
      checkOutput("abortPosition", 64'(positionOut), 64'(modelPos));
      checkOutput("abortDir", 64'(dirOut), 64'd1);
      repeat (400) @(negedge clk);
      checkOutput("abortPositionLater", 64'(positionOut), 64'(modelPos));

      // Time base just below wrap: fires at clock 0x10, edge seen at 0x11.
      rebase(32'hFFFF_FFF0);
      applyStimulus(makeEntry(1'b1, 32'h20, 32'd1, 32'd0, 3'b000));
      expectSteps(1'b1, 32'h20, 1, 32'd0);
      waitDrain(200, "wrapDrain");
      repeat (40) @(negedge clk);

      // Full FIFO: 511 discards plus one valid move fill it; the 513th push must be dropped.
      rebase(32'd100);
      applyStimulus(makeEntry(1'b1, 32'd3000, 32'd1, 32'd0, 3'b000));
      expectSteps(1'b1, 32'd3000, 1, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("fullLongRunning", 64'(runningOut), 64'd1);
      for (int i = 0; i < 511; i++)
         applyStimulus(makeEntry(1'b0, 32'd5, 32'd0, 32'd0, 3'b000));
      applyStimulus(makeEntry(1'b1, 32'd2000, 32'd1, 32'd0, 3'b000));
      applyStimulus(makeEntry(1'b0, 32'd50, 32'd1, 32'd0, 3'b000));
      expectSteps(1'b1, 32'd2000, 1, 32'd0);
      checkOutput("fullNotEmpty", 64'(queueEmpty), 64'd0);
      waitDrain(6000, "fullDrain");
      repeat (300) @(negedge clk);
      checkOutput("fullEmptyEnd", 64'(queueEmpty), 64'd1);
      checkOutput("fullRunningEnd", 64'(runningOut), 64'd0);
      checkOutput("fullPosition", 64'(positionOut), 64'(modelPos));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
